// File: rtl/grn_pkg.sv
// Shared definitions for the GRN attractor sequencer and the host-side job queue.
// State encoding, default counter width/iteration limit and the Moore output decode.
package grn_pkg;

    localparam int CNT_W_DEF    = 16;
    localparam int MAX_ITER_DEF = 1000;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_INIT     = 4'd1,
        ST_FIND_A   = 4'd2,
        ST_FIND_B   = 4'd3,
        ST_FIND_CHK = 4'd4,
        ST_PER_STEP = 4'd5,
        ST_PER_CHK  = 4'd6,
        ST_REWIND   = 4'd7,
        ST_ADV      = 4'd8,
        ST_MU_CHK   = 4'd9,
        ST_MU_A     = 4'd10,
        ST_MU_B     = 4'd11,
        ST_DONE     = 4'd12
    } grn_state_e;

    // Moore strobes for a state: {reset_nos, start_s0, start_s1, busy, res_valid}
    function automatic logic [4:0] grn_decode(input grn_state_e st);
        logic [4:0] d;
        case (st)
            ST_IDLE:     d = 5'b00000;
            ST_INIT:     d = 5'b10010;
            ST_FIND_A:   d = 5'b01110;
            ST_FIND_B:   d = 5'b01110;
            ST_PER_STEP: d = 5'b00110;
            ST_REWIND:   d = 5'b10010;
            ST_ADV:      d = 5'b00110;
            ST_MU_A:     d = 5'b01110;
            ST_MU_B:     d = 5'b01010;
            ST_DONE:     d = 5'b00011;
            default:     d = 5'b00010;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/grn_attractor_ctrl.sv
// Floyd cycle-detection sequencer for a dual-copy boolean GRN node array.
// Finds attractor period and transient length, returned over a valid/ready handshake.
module grn_attractor_ctrl
    import grn_pkg::*;
#(
    parameter int N_NODES  = 8,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_vec,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CNT_W-1:0]   period,
    output logic [CNT_W-1:0]   transient,
    output logic               timeout
);

    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] MAX_ITER_C = CNT_W'(MAX_ITER);

    grn_state_e       state_r;
    grn_state_e       state_nxt_s;
    logic [CNT_W-1:0] k_r;
    logic [CNT_W-1:0] dcnt_r;
    logic [CNT_W-1:0] k_inc_s;
    logic             match_s;

    assign match_s = (s0_vec == s1_vec);
    assign k_inc_s = k_r + CNT_ONE;

    // Next-state selection; match is only meaningful in the CHK states where no enable is active
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_INIT;
                else       state_nxt_s = ST_IDLE;
            end
            ST_INIT:   state_nxt_s = ST_FIND_A;
            ST_FIND_A: state_nxt_s = ST_FIND_B;
            ST_FIND_B: state_nxt_s = ST_FIND_CHK;
            ST_FIND_CHK: begin
                if (match_s)                   state_nxt_s = ST_PER_STEP;
                else if (k_inc_s == MAX_ITER_C) state_nxt_s = ST_DONE;
                else                           state_nxt_s = ST_FIND_A;
            end
            ST_PER_STEP: state_nxt_s = ST_PER_CHK;
            ST_PER_CHK: begin
                if (match_s) state_nxt_s = ST_REWIND;
                else         state_nxt_s = ST_PER_STEP;
            end
            ST_REWIND: state_nxt_s = ST_ADV;
            ST_ADV: begin
                if (dcnt_r == CNT_ONE) state_nxt_s = ST_MU_CHK;
                else                   state_nxt_s = ST_ADV;
            end
            ST_MU_CHK: begin
                if (match_s) state_nxt_s = ST_DONE;
                else         state_nxt_s = ST_MU_A;
            end
            ST_MU_A: state_nxt_s = ST_MU_B;
            ST_MU_B: state_nxt_s = ST_MU_CHK;
            ST_DONE: begin
                if (res_ready) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, counters and strobes; strobes are decoded from the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            reset_nos  <= 1'b0;
            start_s0   <= 1'b0;
            start_s1   <= 1'b0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            init_state <= {N_NODES{1'b0}};
            period     <= CNT_ZERO;
            transient  <= CNT_ZERO;
            timeout    <= 1'b0;
            k_r        <= CNT_ZERO;
            dcnt_r     <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            {reset_nos, start_s0, start_s1, busy, res_valid} <= grn_decode(state_nxt_s);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        init_state <= init_vec;
                        k_r        <= CNT_ZERO;
                        period     <= CNT_ZERO;
                        transient  <= CNT_ZERO;
                        timeout    <= 1'b0;
                    end
                end
                ST_FIND_CHK: begin
                    k_r <= k_inc_s;
                    if (!match_s && (k_inc_s == MAX_ITER_C)) begin
                        timeout   <= 1'b1;
                        period    <= CNT_ZERO;
                        transient <= CNT_ZERO;
                    end
                end
                ST_PER_STEP: period    <= period + CNT_ONE;
                ST_REWIND:   dcnt_r    <= period;
                ST_ADV:      dcnt_r    <= dcnt_r - CNT_ONE;
                ST_MU_B:     transient <= transient + CNT_ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// Table-driven bench for grn_attractor_ctrl with a behavioural dual-copy node network.
// Instance A uses the default iteration limit, instance B a limit of 4 for timeout jobs.
module tb_grn_attractor_ctrl;

    typedef struct {
        logic        which;
        int          mode;
        logic [7:0]  init;
        logic        noise;
        logic        hold;
        logic        early;
        logic [15:0] per;
        logic [15:0] tr;
        logic        to;
        int          cyc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic [7:0] init_vec = 8'h00;
    logic res_ready = 1'b0;
    int mode_a = 0;
    logic sel = 1'b0;

    logic [7:0]  a_s0, a_s1, b_s0, b_s1;
    logic        a_pass, b_pass;
    logic        a_rn, a_e0, a_e1, a_busy, a_valid, a_to;
    logic        b_rn, b_e0, b_e1, b_busy, b_valid, b_to;
    logic [7:0]  a_init, b_init;
    logic [15:0] a_per, a_tr, b_per, b_tr;

    logic [3:0]  o_en;
    logic        o_valid, o_to;
    logic [15:0] o_per, o_tr;
    logic [7:0]  o_init;

    int n_pass = 0;
    int n_total = 0;
    logic [3:0] trace[$];
    logic [3:0] exp_trace[$];
    vec_t tbl[10];

    always #5 clk = ~clk;

    grn_attractor_ctrl #(.N_NODES(8), .CNT_W(16), .MAX_ITER(1000)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .init_vec(init_vec),
        .s0_vec(a_s0), .s1_vec(a_s1), .reset_nos(a_rn), .init_state(a_init),
        .start_s0(a_e0), .start_s1(a_e1), .busy(a_busy), .res_valid(a_valid),
        .res_ready(res_ready), .period(a_per), .transient(a_tr), .timeout(a_to)
    );

    grn_attractor_ctrl #(.N_NODES(8), .CNT_W(16), .MAX_ITER(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .init_vec(init_vec),
        .s0_vec(b_s0), .s1_vec(b_s1), .reset_nos(b_rn), .init_state(b_init),
        .start_s0(b_e0), .start_s1(b_e1), .busy(b_busy), .res_valid(b_valid),
        .res_ready(res_ready), .period(b_per), .transient(b_tr), .timeout(b_to)
    );

    // Network update functions: 0 fixed point, 1 tail 0->1->2->(3->4->2), 2 mod-16 counter
    function automatic logic [7:0] nf(input int m, input logic [7:0] x);
        logic [7:0] y;
        y = 8'd0;
        case (m)
            0: y = x;
            1: begin
                case (x)
                    8'd0: y = 8'd1;
                    8'd1: y = 8'd2;
                    8'd2: y = 8'd3;
                    8'd3: y = 8'd4;
                    8'd4: y = 8'd2;
                    default: y = 8'd0;
                endcase
            end
            default: y = (x + 8'd1) & 8'h0F;
        endcase
        return y;
    endfunction

    // Dual-copy node array model for instance A
    always @(posedge clk) begin
        if (rst) begin
            a_s0 <= 8'd0; a_s1 <= 8'd0; a_pass <= 1'b1;
        end else if (a_rn) begin
            a_s0 <= a_init; a_s1 <= a_init; a_pass <= 1'b1;
        end else begin
            if (a_e0) begin
                if (a_pass) a_s0 <= nf(mode_a, a_s0);
                a_pass <= ~a_pass;
            end
            if (a_e1) a_s1 <= nf(mode_a, a_s1);
        end
    end

    // Dual-copy node array model for instance B (always the counter network)
    always @(posedge clk) begin
        if (rst) begin
            b_s0 <= 8'd0; b_s1 <= 8'd0; b_pass <= 1'b1;
        end else if (b_rn) begin
            b_s0 <= b_init; b_s1 <= b_init; b_pass <= 1'b1;
        end else begin
            if (b_e0) begin
                if (b_pass) b_s0 <= nf(2, b_s0);
                b_pass <= ~b_pass;
            end
            if (b_e1) b_s1 <= nf(2, b_s1);
        end
    end

    always_comb begin
        if (sel) begin
            o_en = {b_rn, b_e0, b_e1, b_busy}; o_valid = b_valid; o_to = b_to;
            o_per = b_per; o_tr = b_tr; o_init = b_init;
        end else begin
            o_en = {a_rn, a_e0, a_e1, a_busy}; o_valid = a_valid; o_to = a_to;
            o_per = a_per; o_tr = a_tr; o_init = a_init;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_job(input vec_t v);
        int cyc;
        logic got;
        trace.delete();
        @(negedge clk);
        sel = v.which;
        init_vec = v.init;
        res_ready = v.early;
        if (v.which == 1'b0) begin
            mode_a = v.mode;
            start_a = 1'b1;
        end else begin
            start_b = 1'b1;
        end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 500) begin
            @(negedge clk);
            cyc++;
            trace.push_back(o_en);
            got = o_valid;
            if (v.noise && (cyc == 5 || cyc == 15)) begin
                start_a = 1'b1;
                init_vec = 8'h02;
            end else begin
                start_a = 1'b0;
            end
        end
        start_a = 1'b0;
        check("latency", 64'(cyc), 64'(v.cyc));
        check("period", 64'(o_per), 64'(v.per));
        check("transient", 64'(o_tr), 64'(v.tr));
        check("timeout", 64'(o_to), 64'(v.to));
        check("init_state", 64'(o_init), 64'(v.init));
        if (v.hold) begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check("hold", {24'd0, o_valid, o_en, o_to, o_per, o_tr},
                      {24'd0, 1'b1, 4'b0001, v.to, v.per, v.tr});
            end
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check("idle_after_ready", {59'd0, o_valid, o_en}, 64'd0);
    endtask

    initial begin
        //           which mode init   noise hold  early  per     tr     to    cyc
        tbl[0] = '{1'b0, 0, 8'h01, 1'b0, 1'b0, 1'b0, 16'd1,  16'd0, 1'b0, 10};
        tbl[1] = '{1'b0, 1, 8'h00, 1'b0, 1'b0, 1'b0, 16'd3,  16'd2, 1'b0, 28};
        tbl[2] = '{1'b0, 1, 8'h02, 1'b0, 1'b0, 1'b0, 16'd3,  16'd0, 1'b0, 22};
        tbl[3] = '{1'b0, 1, 8'h01, 1'b0, 1'b0, 1'b0, 16'd3,  16'd1, 1'b0, 25};
        tbl[4] = '{1'b0, 2, 8'h00, 1'b0, 1'b0, 1'b0, 16'd16, 16'd0, 1'b0, 100};
        tbl[5] = '{1'b1, 2, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0,  16'd0, 1'b1, 14};
        tbl[6] = '{1'b0, 1, 8'h00, 1'b1, 1'b0, 1'b0, 16'd3,  16'd2, 1'b0, 28};
        tbl[7] = '{1'b0, 0, 8'hA5, 1'b0, 1'b1, 1'b0, 16'd1,  16'd0, 1'b0, 10};
        tbl[8] = '{1'b0, 1, 8'h01, 1'b0, 1'b0, 1'b1, 16'd3,  16'd1, 1'b0, 25};
        tbl[9] = '{1'b1, 2, 8'h03, 1'b0, 1'b0, 1'b0, 16'd0,  16'd0, 1'b1, 14};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_a", {a_rn, a_e0, a_e1, a_busy, a_valid, a_to, a_init, a_per, a_tr}, 64'd0);
        check("reset_b", {b_rn, b_e0, b_e1, b_busy, b_valid, b_to, b_init, b_per, b_tr}, 64'd0);

        for (int i = 0; i < 10; i++) run_job(tbl[i]);

        // Cycle-by-cycle strobe sequence for the tail-into-3-cycle network
        exp_trace.delete();
        exp_trace.push_back(4'b1001);
        for (int i = 0; i < 3; i++) begin
            exp_trace.push_back(4'b0111); exp_trace.push_back(4'b0111); exp_trace.push_back(4'b0001);
        end
        for (int i = 0; i < 3; i++) begin
            exp_trace.push_back(4'b0011); exp_trace.push_back(4'b0001);
        end
        exp_trace.push_back(4'b1001);
        for (int i = 0; i < 3; i++) exp_trace.push_back(4'b0011);
        exp_trace.push_back(4'b0001);
        for (int i = 0; i < 2; i++) begin
            exp_trace.push_back(4'b0111); exp_trace.push_back(4'b0101); exp_trace.push_back(4'b0001);
        end
        exp_trace.push_back(4'b0001);
        run_job(tbl[1]);
        check("trace_len", 64'(trace.size()), 64'(exp_trace.size()));
        for (int i = 0; i < exp_trace.size(); i++) begin
            if (i < trace.size()) check($sformatf("trace_c%0d", i + 1), 64'(trace[i]), 64'(exp_trace[i]));
        end

        // Reset while the job is in FIND_B, then a clean job
        @(negedge clk);
        sel = 1'b0;
        mode_a = 1;
        init_vec = 8'h00;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        check("find_b_enables", 64'({a_rn, a_e0, a_e1, a_busy}), 64'(4'b0111));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_reset", {a_rn, a_e0, a_e1, a_busy, a_valid, a_to, a_init, a_per, a_tr}, 64'd0);
        run_job(tbl[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
